// File: rtl/pipe_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_sequencer                                                  |
// | Purpose  : run/halt/single-step control plus hazard-driven stage enables,  |
// |            flush strobes and saturating stall/flush counters.              |
// | Options  : PIPE_SEQ_STEP_EN builds the single-step state and its edge reg. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_wb,
  input  logic             load_use,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0]       C_IDLE   = 2'd0;
  localparam logic [1:0]       C_RUN    = 2'd1;
  localparam logic [1:0]       C_STEP   = 2'd2;
  localparam logic [1:0]       C_HALTED = 2'd3;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_run_prev;
  logic             w_run_edge;
  logic             w_step_edge;
  logic             w_advance;
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_run_edge = run_req & ~r_run_prev;

`ifdef PIPE_SEQ_STEP_EN
  logic r_step_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_step_prev <= 1'b0;
    else      r_step_prev <= step_req;
  end

  assign w_step_edge = step_req & ~r_step_prev;
`else
  // Single-step is not built; the input is kept only for port compatibility.
  logic w_unused_step;
  assign w_unused_step = step_req;
  assign w_step_edge   = 1'b0;
`endif

  // State register and request edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= C_IDLE;
      r_run_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_prev <= run_req;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_run_edge)       w_state_nxt = C_RUN;
        else if (w_step_edge) w_state_nxt = C_STEP;
      end
      C_RUN: begin
        if (halt_wb)         w_state_nxt = C_HALTED;
        else if (w_run_edge) w_state_nxt = C_IDLE;
      end
`ifdef PIPE_SEQ_STEP_EN
      C_STEP:   w_state_nxt = halt_wb ? C_HALTED : C_IDLE;
`endif
      C_HALTED: w_state_nxt = C_HALTED;
      default:  w_state_nxt = C_IDLE;
    endcase
  end

  // Output logic: the branch in EXE is older than the load-use in ID, so it wins
  assign w_advance = ((r_state == C_RUN) || (r_state == C_STEP)) && !halt_wb;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_exe_en    = 1'b0;
    exe_mem_en   = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    if (w_advance) begin
      pc_en      = 1'b1;
      if_id_en   = 1'b1;
      id_exe_en  = 1'b1;
      exe_mem_en = 1'b1;
      mem_wb_en  = 1'b1;
      if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
      end
    end
  end

  assign w_stall_evt = w_advance & load_use & ~branch_taken;
  assign w_flush_evt = w_advance & branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != C_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != C_CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// Self-checking bench for pipe_sequencer: directed scenarios plus a randomized
// run checked against a rule-level reference model (counters are 4 bits wide).
module tb_pipe_sequencer;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
`ifdef PIPE_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run_req, step_req, halt_wb, load_use, branch_taken;
  logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       outs;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0=idle 1=run 2=step 3=halted
  int m_st, m_stall, m_flush;
  bit m_prun, m_pstep;

  pipe_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_wb(halt_wb), .load_use(load_use), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush};

  // {pc, if_id, id_exe, exe_mem, mem_wb enables, if_id flush, id_exe flush}
  function automatic logic [6:0] exp_outs(int st, logic h, logic l, logic b);
    if (!((st == 1 || st == 2) && !h)) return 7'b0000000;
    if (b) return 7'b1111111;
    if (l) return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_stall = 0; m_flush = 0; m_prun = 0; m_pstep = 0;
  endtask

  task automatic model_edge();
    bit re, se, adv;
    re  = run_req && !m_prun;
    se  = STEP_EN && step_req && !m_pstep;
    adv = (m_st == 1 || m_st == 2) && !halt_wb;
    if (adv && branch_taken) m_flush = sat_inc(m_flush);
    if (adv && load_use && !branch_taken) m_stall = sat_inc(m_stall);
    case (m_st)
      0: if (re) m_st = 1; else if (se) m_st = 2;
      1: if (halt_wb) m_st = 3; else if (re) m_st = 0;
      2: m_st = halt_wb ? 3 : 0;
      default: m_st = 3;
    endcase
    m_prun  = run_req;
    m_pstep = step_req;
  endtask

  // called at a falling edge; leaves inputs settled 1 ns later
  task automatic apply(logic r, logic s, logic h, logic l, logic b);
    run_req = r; step_req = s; halt_wb = h; load_use = l; branch_taken = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    total++;
    if (outs !== 7'd0 || state !== 2'd0) begin
      bad++; $display("FAIL reset_hold: outs=%b state=%0d want 0/0", outs, state);
    end
    rst = 1'b1;
    #1;
    total++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || outs !== 7'd0) begin
      bad++; $display("FAIL reset_cnt: stall=%0d flush=%0d outs=%b want 0", stall_cnt, flush_cnt, outs);
    end
    @(negedge clk);
  endtask

  task automatic test_run_start();
    do_reset();
    apply(1, 0, 0, 0, 0);
    total++;
    if (state !== 2'd0 || outs !== 7'd0) begin
      bad++; $display("FAIL run_pre: state=%0d outs=%b want 0", state, outs);
    end
    tick();
    apply(1, 0, 0, 0, 0);
    total++;
    if (state !== 2'd1 || outs !== 7'b1111100 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      bad++; $display("FAIL run_go: state=%0d outs=%b stall=%0d flush=%0d want 1/1111100/0/0",
                      state, outs, stall_cnt, flush_cnt);
    end
    tick();
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL run_held_once: state=%0d want 1", state);
    end
    apply(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_load_use();
    apply(0, 0, 0, 1, 0);
    total++;
    if (outs !== 7'b0011101) begin
      bad++; $display("FAIL load_use_outs: got %b want 0011101", outs);
    end
    tick();
    apply(0, 0, 0, 0, 0);
    total++;
    if (stall_cnt !== 4'd1 || outs !== 7'b1111100) begin
      bad++; $display("FAIL load_use_cnt: stall=%0d outs=%b want 1/1111100", stall_cnt, outs);
    end
  endtask

  task automatic test_branch_over_load();
    apply(0, 0, 0, 1, 1);
    total++;
    if (outs !== 7'b1111111) begin
      bad++; $display("FAIL branch_outs: got %b want 1111111", outs);
    end
    tick();
    apply(0, 0, 0, 0, 0);
    total++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
      bad++; $display("FAIL branch_cnt: flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_halt();
    apply(0, 0, 1, 1, 1);
    total++;
    if (outs !== 7'd0) begin
      bad++; $display("FAIL halt_outs: got %b want 0", outs);
    end
    tick();
    apply(0, 0, 0, 0, 0);
    total++;
    if (state !== 2'd3 || flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
      bad++; $display("FAIL halt_state: state=%0d flush=%0d stall=%0d want 3/1/1", state, flush_cnt, stall_cnt);
    end
    apply(1, 0, 0, 0, 0); tick();
    apply(0, 1, 0, 1, 1); tick();
    apply(1, 0, 0, 0, 1); tick();
    total++;
    if (state !== 2'd3 || outs !== 7'd0) begin
      bad++; $display("FAIL halt_sticky: state=%0d outs=%b want 3/0", state, outs);
    end
    rst = 1'b0;
    #1;
    total++;
    if (state !== 2'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      bad++; $display("FAIL halt_reset: state=%0d stall=%0d flush=%0d want 0", state, stall_cnt, flush_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_async_reset_mid_run();
    do_reset();
    apply(1, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 0); tick();
    apply(0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (state !== 2'd0 || outs !== 7'd0 || stall_cnt !== 4'd0) begin
      bad++; $display("FAIL async_reset: state=%0d outs=%b stall=%0d want 0", state, outs, stall_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_step();
    int adv_cycles;
    do_reset();
    apply(1, 1, 0, 0, 0);
    tick();
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL run_and_step_edge: state=%0d want 1", state);
    end
    do_reset();
    adv_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 0, 0);
      if (pc_en === 1'b1) adv_cycles++;
      tick();
    end
    apply(0, 0, 0, 0, 0);
    total++;
    if (adv_cycles !== (STEP_EN ? 1 : 0) || state !== 2'd0) begin
      bad++; $display("FAIL step_once: advances=%0d state=%0d want %0d/0", adv_cycles, state, STEP_EN ? 1 : 0);
    end
    if (STEP_EN) begin
      do_reset();
      apply(0, 1, 0, 0, 0); tick();
      apply(0, 1, 0, 0, 0);
      total++;
      if (state !== 2'd2 || outs !== 7'b1111100) begin
        bad++; $display("FAIL step_state: state=%0d outs=%b want 2/1111100", state, outs);
      end
      tick();
      total++;
      if (state !== 2'd0) begin
        bad++; $display("FAIL step_return: state=%0d want 0", state);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    apply(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 1, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0);
    total++;
    if (stall_cnt !== 4'd15 || state !== 2'd1) begin
      bad++; $display("FAIL stall_saturate: stall=%0d state=%0d want 15/1", stall_cnt, state);
    end
  endtask

  task automatic test_random();
    logic r;
    logic [6:0] e;
    do_reset();
    r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        do_reset();
        r = 1'b0;
      end
      if ($urandom_range(7) == 0) r = ~r;
      apply(r, 1'($urandom_range(1)), ($urandom_range(40) == 0),
            1'($urandom_range(1)), ($urandom_range(3) == 0));
      e = exp_outs(m_st, halt_wb, load_use, branch_taken);
      total++;
      if (outs !== e || state !== 2'(m_st) || stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
        bad++;
        $display("FAIL random[%0d]: outs=%b st=%0d stall=%0d flush=%0d want %b/%0d/%0d/%0d",
                 i, outs, state, stall_cnt, flush_cnt, e, m_st, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    apply(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_run_start();
    test_load_use();
    test_branch_over_load();
    test_halt();
    test_async_reset_mid_run();
    test_step();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
